// File: rtl/sysid_check_master_if.sv
// ---------------------------------------------------------------------------
// sysid_check_master_if
// Avalon-MM read-only bus between the system-ID check initiator and the
// system-ID responder.
//   avm_address     : word address, 0 = system ID, 1 = build timestamp
//   avm_read        : read strobe from the initiator
//   avm_readdata    : read data, valid when avm_read=1 and avm_waitrequest=0
//   avm_waitrequest : responder stall
// Modports: master (initiator side), slave (responder side).
// ---------------------------------------------------------------------------
interface sysid_check_master_if;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest
  );
endinterface

// File: rtl/sysid_check_master.sv
// ---------------------------------------------------------------------------
// sysid_check_master
// Hardware self-check that reads the system-ID responder (word 0 = system ID,
// word 1 = build timestamp) over Avalon-MM and compares both words against
// the values this image was built with. Stalled reads are abandoned after
// TIMEOUT_CYCLES and re-issued up to MAX_RETRIES times per check.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   start        : one-cycle request to run a check (IDLE/DONE only)
//   avm          : Avalon-MM master bus (see sysid_check_master_if)
//   busy         : check in progress
//   done         : one-cycle completion pulse
//   pass         : id_ok & ts_ok & ~timeout
//   id_ok, ts_ok : captured words match the expected values
//   timeout      : retries exhausted
//   id_value     : captured system ID
//   ts_value     : captured build timestamp
// All outputs are registered.
// ---------------------------------------------------------------------------
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1520626481,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  sysid_check_master_if.master         avm,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         id_ok,
  output logic                         ts_ok,
  output logic                         timeout,
  output logic [31:0]                  id_value,
  output logic [31:0]                  ts_value
);

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int unsigned      TW        = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]    TC_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]    TC_ZERO   = {TW{1'b0}};
  localparam logic [TW-1:0]    TC_ONE    = TW'(1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_ID = 3'd1,
    S_RD_TS = 3'd2,
    S_RETRY = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Full 32-bit word comparison used for both checks.
  function automatic logic f_word_match(input logic [31:0] a, input logic [31:0] b);
    return (a == b);
  endfunction

  state_t          r_state;
  logic [TW-1:0]   r_tcnt;
  logic [3:0]      r_retry;
  logic            r_retry_ts;
  logic            r_read;
  logic            r_address;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic            r_id_ok;
  logic            r_ts_ok;
  logic            r_timeout;
  logic [31:0]     r_id_value;
  logic [31:0]     r_ts_value;

  state_t          w_state_nxt;
  logic [TW-1:0]   w_tcnt_nxt;
  logic [3:0]      w_retry_nxt;
  logic            w_retry_ts_nxt;
  logic            w_read_nxt;
  logic            w_address_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic            w_pass_nxt;
  logic            w_id_ok_nxt;
  logic            w_ts_ok_nxt;
  logic            w_timeout_nxt;
  logic [31:0]     w_id_value_nxt;
  logic [31:0]     w_ts_value_nxt;
  logic            w_id_match;
  logic            w_ts_match;

  assign w_id_match = f_word_match(r_id_value, EXPECTED_ID);
  assign w_ts_match = f_word_match(r_ts_value, EXPECTED_TIMESTAMP);

  // Next-state, counters and result flags.
  always_comb begin
    w_state_nxt    = r_state;
    w_tcnt_nxt     = r_tcnt;
    w_retry_nxt    = r_retry;
    w_retry_ts_nxt = r_retry_ts;
    w_pass_nxt     = r_pass;
    w_id_ok_nxt    = r_id_ok;
    w_ts_ok_nxt    = r_ts_ok;
    w_timeout_nxt  = r_timeout;
    w_id_value_nxt = r_id_value;
    w_ts_value_nxt = r_ts_value;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_id_ok_nxt    = 1'b0;
          w_ts_ok_nxt    = 1'b0;
          w_pass_nxt     = 1'b0;
          w_timeout_nxt  = 1'b0;
          w_retry_nxt    = 4'd0;
          w_retry_ts_nxt = 1'b0;
          w_tcnt_nxt     = TC_ZERO;
          w_state_nxt    = S_RD_ID;
        end else begin
          w_state_nxt    = r_state;
        end
      end

      S_RD_ID, S_RD_TS: begin
        if (!avm.avm_waitrequest) begin
          // Completion wins even when the counter is at its last value.
          w_tcnt_nxt = TC_ZERO;
          if (r_state == S_RD_ID) begin
            w_id_value_nxt = avm.avm_readdata;
            w_state_nxt    = S_RD_TS;
          end else begin
            w_ts_value_nxt = avm.avm_readdata;
            w_state_nxt    = S_CHECK;
          end
        end else if (r_tcnt == TC_LAST) begin
          w_tcnt_nxt = TC_ZERO;
          if (r_retry < RETRY_MAX) begin
            // Retry budget is shared by both reads of one check.
            w_retry_nxt    = r_retry + 4'd1;
            w_retry_ts_nxt = (r_state == S_RD_TS);
            w_state_nxt    = S_RETRY;
          end else begin
            w_timeout_nxt  = 1'b1;
            w_state_nxt    = S_CHECK;
          end
        end else begin
          w_tcnt_nxt = r_tcnt + TC_ONE;
        end
      end

      S_RETRY: begin
        w_tcnt_nxt = TC_ZERO;
        if (r_retry_ts) begin
          w_state_nxt = S_RD_TS;
        end else begin
          w_state_nxt = S_RD_ID;
        end
      end

      S_CHECK: begin
        // A timed-out check never reports a match, whatever was captured.
        w_id_ok_nxt = w_id_match & ~r_timeout;
        w_ts_ok_nxt = w_ts_match & ~r_timeout;
        w_pass_nxt  = w_id_match & w_ts_match & ~r_timeout;
        w_state_nxt = S_DONE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Bus strobe and status decoded from the next state so they can be registered.
  always_comb begin
    w_read_nxt    = 1'b0;
    w_address_nxt = 1'b0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = (r_state == S_CHECK);
    case (w_state_nxt)
      S_RD_ID: begin
        w_read_nxt    = 1'b1;
        w_address_nxt = 1'b0;
        w_busy_nxt    = 1'b1;
      end
      S_RD_TS: begin
        w_read_nxt    = 1'b1;
        w_address_nxt = 1'b1;
        w_busy_nxt    = 1'b1;
      end
      S_RETRY, S_CHECK: begin
        w_busy_nxt    = 1'b1;
      end
      default: begin
        w_busy_nxt    = 1'b0;
      end
    endcase
  end

  // State, counters and every output register; reset clears them immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tcnt     <= TC_ZERO;
      r_retry    <= 4'd0;
      r_retry_ts <= 1'b0;
      r_read     <= 1'b0;
      r_address  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= 32'd0;
      r_ts_value <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_retry    <= w_retry_nxt;
      r_retry_ts <= w_retry_ts_nxt;
      r_read     <= w_read_nxt;
      r_address  <= w_address_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
      r_id_ok    <= w_id_ok_nxt;
      r_ts_ok    <= w_ts_ok_nxt;
      r_timeout  <= w_timeout_nxt;
      r_id_value <= w_id_value_nxt;
      r_ts_value <= w_ts_value_nxt;
    end
  end

  assign avm.avm_read    = r_read;
  assign avm.avm_address = r_address;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign id_ok           = r_id_ok;
  assign ts_ok           = r_ts_ok;
  assign timeout         = r_timeout;
  assign id_value        = r_id_value;
  assign ts_value        = r_ts_value;

endmodule

// File: tb/tb_sysid_check_master.sv
// ---------------------------------------------------------------------------
// tb_sysid_check_master
// Directed stimulus with a scoreboard: each start pushes its expected result,
// a monitor pops and compares on every done pulse. A responder model answers
// reads with per-attempt stall lengths and checks bus stability.
// ---------------------------------------------------------------------------
module tb_sysid_check_master;

  localparam logic [31:0] TS = 32'd1520626481;
  localparam int          TO = 8;

  typedef struct {
    string       name;
    logic        id_ok;
    logic        ts_ok;
    logic        pass;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    int          lat;
    int          n_att;
    logic [15:0] addr_log;
    int          start_cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] mem0 = 32'd0;
  logic [31:0] mem1 = TS;

  exp_t sb_q[$];
  int   stall_q[$];

  sysid_check_master_if bus();

  sysid_check_master #(
    .EXPECTED_ID        (32'd0),
    .EXPECTED_TIMESTAMP (TS),
    .TIMEOUT_CYCLES     (TO),
    .MAX_RETRIES        (2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .avm      (bus),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .id_ok    (id_ok),
    .ts_ok    (ts_ok),
    .timeout  (timeout),
    .id_value (id_value),
    .ts_value (ts_value)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  assign bus.avm_readdata = bus.avm_address ? mem1 : mem0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- responder model ----------------
  int          cur_left = 0;
  int          stall_run = 0;
  int          att_cnt = 0;
  logic [15:0] addr_log = 16'd0;
  logic        prev_read = 1'b0;
  logic        prev_addr = 1'b0;
  logic        prev_wr = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      cur_left = 0;
      stall_run = 0;
      prev_read = 1'b0;
      prev_addr = 1'b0;
      prev_wr = 1'b0;
      bus.avm_waitrequest = 1'b0;
    end else begin
      if (bus.avm_read) check("read_only_when_busy", 32'(busy), 32'd1);
      if (prev_wr) begin
        if (stall_run == TO) begin
          check("abandon_after_timeout", 32'(bus.avm_read), 32'd0);
        end else begin
          check("read_held_in_stall", 32'(bus.avm_read), 32'd1);
          check("addr_held_in_stall", 32'(bus.avm_address), 32'(prev_addr));
        end
      end
      if (bus.avm_read && (!prev_read || bus.avm_address != prev_addr)) begin
        cur_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
        stall_run = 0;
        att_cnt++;
        addr_log = {addr_log[14:0], bus.avm_address};
      end
      prev_wr = bus.avm_read && (cur_left > 0);
      if (prev_wr) begin
        cur_left--;
        stall_run++;
      end
      bus.avm_waitrequest = prev_wr;
      prev_read = bus.avm_read;
      prev_addr = bus.avm_address;
    end
  end

  // ---------------- monitor ----------------
  exp_t        mon_e;
  int          att_base = 0;
  logic        prev_done = 1'b0;
  logic [15:0] mon_mask;

  always @(negedge clock) begin
    if (reset) begin
      att_base = att_cnt;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        check("done_single_cycle", 32'(prev_done), 32'd0);
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done=1 expected no pending check (cycle %0d)", cyc);
        end else begin
          mon_e = sb_q.pop_front();
          check({mon_e.name, ".id_ok"},    32'(id_ok),    32'(mon_e.id_ok));
          check({mon_e.name, ".ts_ok"},    32'(ts_ok),    32'(mon_e.ts_ok));
          check({mon_e.name, ".pass"},     32'(pass),     32'(mon_e.pass));
          check({mon_e.name, ".timeout"},  32'(timeout),  32'(mon_e.timeout));
          check({mon_e.name, ".id_value"}, id_value,      mon_e.id_value);
          check({mon_e.name, ".ts_value"}, ts_value,      mon_e.ts_value);
          check({mon_e.name, ".busy"},     32'(busy),     32'd0);
          check({mon_e.name, ".latency"},  32'(cyc - mon_e.start_cyc), 32'(mon_e.lat));
          check({mon_e.name, ".attempts"}, 32'(att_cnt - att_base),    32'(mon_e.n_att));
          mon_mask = (16'd1 << mon_e.n_att) - 16'd1;
          check({mon_e.name, ".addr_seq"}, 32'(addr_log & mon_mask), 32'(mon_e.addr_log));
          att_base = att_cnt;
        end
      end
      prev_done = done;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic exp_t mk(input string nm, input logic iok, input logic tok, input logic ps,
                              input logic to, input logic [31:0] idv, input logic [31:0] tsv,
                              input int lat, input int natt, input logic [15:0] alog);
    exp_t e;
    e.name = nm; e.id_ok = iok; e.ts_ok = tok; e.pass = ps; e.timeout = to;
    e.id_value = idv; e.ts_value = tsv; e.lat = lat; e.n_att = natt;
    e.addr_log = alog; e.start_cyc = 0;
    return e;
  endfunction

  // Called at a negedge; leaves start low at the following negedge.
  task automatic issue(input exp_t e);
    exp_t x;
    x = e;
    x.start_cyc = cyc;
    sb_q.push_back(x);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (done) break;
      @(negedge clock);
    end
    if (k == budget) begin
      vectors++;
      miscompares++;
      $display("FAIL %s.done_wait: got no done expected done within %0d cycles", nm, budget);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    repeat (3) @(negedge clock);
    check("rst.read",     32'(bus.avm_read), 32'd0);
    check("rst.busy",     32'(busy),         32'd0);
    check("rst.done",     32'(done),         32'd0);
    check("rst.pass",     32'(pass),         32'd0);
    check("rst.id_value", id_value,          32'd0);
    check("rst.ts_value", ts_value,          32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle.busy", 32'(busy), 32'd0);
    check("idle.read", 32'(bus.avm_read), 32'd0);

    // 1: nominal
    issue(mk("nominal", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS, 4, 2, 16'h0001));
    wait_done("nominal", 50);
    @(negedge clock);

    // 2: timestamp off by one
    mem1 = TS - 32'd1;
    issue(mk("bad_ts", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, TS - 32'd1, 4, 2, 16'h0001));
    wait_done("bad_ts", 50);
    @(negedge clock);

    // 2b: wrong ID, then restart on the done cycle
    mem0 = 32'd1;
    mem1 = TS;
    issue(mk("bad_id", 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, TS, 4, 2, 16'h0001));
    wait_done("bad_id", 50);
    mem0 = 32'd0;
    issue(mk("restart_on_done", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS, 4, 2, 16'h0001));
    wait_done("restart_on_done", 50);
    @(negedge clock);

    // 3: five-cycle stall on each read
    stall_q = '{5, 5};
    issue(mk("stall5", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS, 14, 2, 16'h0001));
    wait_done("stall5", 60);
    @(negedge clock);

    // 4: stuck waitrequest, three attempts at address 0
    stall_q = '{100, 100, 100};
    issue(mk("stuck", 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, TS, 28, 3, 16'h0000));
    wait_done("stuck", 80);
    @(negedge clock);
    check("stuck.busy_after", 32'(busy), 32'd0);

    // 5: first ID attempt times out, retry succeeds
    stall_q = '{8, 0, 0};
    issue(mk("one_retry", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS, 13, 3, 16'h0001));
    wait_done("one_retry", 60);
    @(negedge clock);

    // waitrequest drops exactly when the counter reaches its last value
    stall_q = '{7, 0};
    issue(mk("edge_success", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS, 11, 2, 16'h0001));
    wait_done("edge_success", 60);
    @(negedge clock);

    // retries shared across both reads; ID matches but timeout forces id_ok low
    stall_q = '{8, 0, 8, 8};
    issue(mk("shared_retry", 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, TS, 29, 4, 16'h0003));
    wait_done("shared_retry", 80);
    @(negedge clock);

    // start while busy is ignored
    stall_q = '{5, 5};
    issue(mk("start_busy", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS, 14, 2, 16'h0001));
    repeat (2) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("start_busy", 60);
    repeat (10) @(negedge clock);
    check("start_busy.idle_read", 32'(bus.avm_read), 32'd0);
    check("start_busy.idle_busy", 32'(busy), 32'd0);

    // 6: reset during the timestamp stall
    mem0 = 32'hA5A5_0001;
    stall_q = '{0, 20};
    issue(mk("aborted", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 0, 0, 16'h0000));
    for (k = 0; k < 20; k++) begin
      if (bus.avm_read && bus.avm_address) break;
      @(negedge clock);
    end
    check("rd_ts_reached", 32'(bus.avm_read && bus.avm_address), 32'd1);
    @(negedge clock);
    check("pre_reset.id_value", id_value, 32'hA5A5_0001);
    #1 reset = 1'b1;
    #1;
    check("async_rst.read",     32'(bus.avm_read),    32'd0);
    check("async_rst.address",  32'(bus.avm_address), 32'd0);
    check("async_rst.busy",     32'(busy),            32'd0);
    check("async_rst.id_value", id_value,             32'd0);
    check("async_rst.ts_value", ts_value,             32'd0);
    check("async_rst.pass",     32'(pass),            32'd0);
    sb_q.delete();
    stall_q.delete();
    mem0 = 32'd0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst.busy", 32'(busy), 32'd0);
    issue(mk("after_reset", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS, 4, 2, 16'h0001));
    wait_done("after_reset", 50);

    repeat (5) @(negedge clock);
    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pending_checks: got %0d outstanding expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
